cdb_arbiter: RTL and testbench

//  Single common-data-bus arbiter between the ALU and LSB writeback sources.

---
 rtl/cdb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Single common-data-bus arbiter shared by the ALU and LSB writeback paths.
// Each source pushes {reorder tag, result} into its own circular FIFO. At most
// one head entry per cycle is granted, round-robin between the two FIFOs, onto a
// registered CDB. The CDB feeds the RS/LSB/ROB wakeup inputs in place of two
// separate broadcast buses.
//
// Ports
//   in_clk, in_rst        clock (rising edge), asynchronous active-high reset
//   in_rdy                global enable; low freezes every register
//   in_clear              misprediction flush: empties both FIFOs, kills the CDB
//   in_alu_*              ALU push (enable, ROB tag, result); out_alu_full = hold
//   in_lsb_*              LSB push (enable, ROB tag, result); out_lsb_full = hold
//   out_cdb_*             registered broadcast (valid, ROB tag, value)
//   out_overflow          sticky flag: a push arrived while its FIFO was full
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_rdy,
    input  logic                  in_clear,
    input  logic                  in_alu_enable,
    input  logic [ROB_WIDTH-1:0]  in_alu_reorder,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    output logic                  out_alu_full,
    input  logic                  in_lsb_enable,
    input  logic [ROB_WIDTH-1:0]  in_lsb_reorder,
    input  logic [DATA_WIDTH-1:0] in_lsb_result,
    output logic                  out_lsb_full,
    output logic                  out_cdb_enable,
    output logic [ROB_WIDTH-1:0]  out_cdb_reorder,
    output logic [DATA_WIDTH-1:0] out_cdb_result,
    output logic                  out_overflow
);

    localparam logic [PTR_W:0]         FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]         COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]       PTR_ONE    = PTR_W'(1);
    localparam logic [ROB_WIDTH-1:0]   ZERO_ROB   = '0;

    // FIFO storage (no reset needed: validity is tracked by the counts)
    logic [ROB_WIDTH-1:0]  alu_tag_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] alu_res_mem [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0]  lsb_tag_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] lsb_res_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr, lsb_wr_ptr, lsb_rd_ptr;
    logic [PTR_W:0]   alu_count, lsb_count;

    // Round-robin state: 1 when the LSB queue received the most recent grant.
    logic last_lsb;

    logic active;
    logic alu_non_empty, lsb_non_empty;
    logic grant_alu, grant_lsb;
    logic pop_alu, pop_lsb;
    logic push_alu, push_lsb;
    logic accept_alu, accept_lsb;
    logic drop_alu, drop_lsb;

    assign out_alu_full = (alu_count == FULL_COUNT);
    assign out_lsb_full = (lsb_count == FULL_COUNT);

    // Arbitration and push acceptance. A full queue still accepts a push in the
    // same cycle it pops, because the pop frees the slot at that very edge.
    always_comb begin
        active        = in_rdy && !in_clear;
        alu_non_empty = (alu_count != '0);
        lsb_non_empty = (lsb_count != '0);
        grant_alu     = alu_non_empty && (!lsb_non_empty || last_lsb);
        grant_lsb     = lsb_non_empty && (!alu_non_empty || !last_lsb);
        pop_alu       = active && grant_alu;
        pop_lsb       = active && grant_lsb;
        push_alu      = active && in_alu_enable;
        push_lsb      = active && in_lsb_enable;
        accept_alu    = push_alu && (!out_alu_full || pop_alu);
        accept_lsb    = push_lsb && (!out_lsb_full || pop_lsb);
        drop_alu      = push_alu && !accept_alu;
        drop_lsb      = push_lsb && !accept_lsb;
    end

    // Storage writes at the current write pointers.
    always_ff @(posedge in_clk) begin
        if (accept_alu) begin
            alu_tag_mem[alu_wr_ptr] <= in_alu_reorder;
            alu_res_mem[alu_wr_ptr] <= in_alu_result;
        end
        if (accept_lsb) begin
            lsb_tag_mem[lsb_wr_ptr] <= in_lsb_reorder;
            lsb_res_mem[lsb_wr_ptr] <= in_lsb_result;
        end
    end

    // ALU queue pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_count  <= '0;
        end else if (in_rdy) begin
            if (in_clear) begin
                alu_wr_ptr <= '0;
                alu_rd_ptr <= '0;
                alu_count  <= '0;
            end else begin
                if (accept_alu) alu_wr_ptr <= alu_wr_ptr + PTR_ONE;
                if (pop_alu)    alu_rd_ptr <= alu_rd_ptr + PTR_ONE;
                if (accept_alu && !pop_alu)      alu_count <= alu_count + COUNT_ONE;
                else if (!accept_alu && pop_alu) alu_count <= alu_count - COUNT_ONE;
            end
        end
    end

    // LSB queue pointers and occupancy.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            lsb_wr_ptr <= '0;
            lsb_rd_ptr <= '0;
            lsb_count  <= '0;
        end else if (in_rdy) begin
            if (in_clear) begin
                lsb_wr_ptr <= '0;
                lsb_rd_ptr <= '0;
                lsb_count  <= '0;
            end else begin
                if (accept_lsb) lsb_wr_ptr <= lsb_wr_ptr + PTR_ONE;
                if (pop_lsb)    lsb_rd_ptr <= lsb_rd_ptr + PTR_ONE;
                if (accept_lsb && !pop_lsb)      lsb_count <= lsb_count + COUNT_ONE;
                else if (!accept_lsb && pop_lsb) lsb_count <= lsb_count - COUNT_ONE;
            end
        end
    end

    // Registered CDB, round-robin state and sticky overflow. A flush leaves the
    // round-robin state untouched; an idle cycle keeps the last tag/value.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_cdb_enable  <= 1'b0;
            out_cdb_reorder <= ZERO_ROB;
            out_cdb_result  <= '0;
            out_overflow    <= 1'b0;
            last_lsb        <= 1'b0;
        end else if (in_rdy) begin
            if (in_clear) begin
                out_cdb_enable <= 1'b0;
            end else begin
                if (pop_alu) begin
                    out_cdb_enable  <= 1'b1;
                    out_cdb_reorder <= alu_tag_mem[alu_rd_ptr];
                    out_cdb_result  <= alu_res_mem[alu_rd_ptr];
                    last_lsb        <= 1'b0;
                end else if (pop_lsb) begin
                    out_cdb_enable  <= 1'b1;
                    out_cdb_reorder <= lsb_tag_mem[lsb_rd_ptr];
                    out_cdb_result  <= lsb_res_mem[lsb_rd_ptr];
                    last_lsb        <= 1'b1;
                end else begin
                    out_cdb_enable <= 1'b0;
                end
                if (drop_alu || drop_lsb) out_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model of the arbiter.
module tb_cdb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        clear = 1'b0;
    logic        alu_en = 1'b0;
    logic [3:0]  alu_tag = '0;
    logic [31:0] alu_res = '0;
    logic        lsb_en = 1'b0;
    logic [3:0]  lsb_tag = '0;
    logic [31:0] lsb_res = '0;
    logic        alu_full, lsb_full;
    logic        cdb_en;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_res;
    logic        overflow;

    int test_count = 0;
    int fail_count = 0;

    // Reference model state
    logic [35:0] qa[$];
    logic [35:0] qb[$];
    logic        m_en, m_ovf, m_last_lsb;
    logic [3:0]  m_tag;
    logic [31:0] m_res;

    cdb_arbiter #(.FIFO_DEPTH(4), .PTR_W(2), .ROB_WIDTH(4), .DATA_WIDTH(32)) dut (
        .in_clk(clk),
        .in_rst(rst),
        .in_rdy(rdy),
        .in_clear(clear),
        .in_alu_enable(alu_en),
        .in_alu_reorder(alu_tag),
        .in_alu_result(alu_res),
        .out_alu_full(alu_full),
        .in_lsb_enable(lsb_en),
        .in_lsb_reorder(lsb_tag),
        .in_lsb_result(lsb_res),
        .out_lsb_full(lsb_full),
        .out_cdb_enable(cdb_en),
        .out_cdb_reorder(cdb_tag),
        .out_cdb_result(cdb_res),
        .out_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        qa.delete();
        qb.delete();
        m_en = 0; m_ovf = 0; m_last_lsb = 0; m_tag = '0; m_res = '0;
    endfunction

    // One clock edge of the arbiter's specified behaviour.
    function automatic void model_step(input logic r, input logic c,
                                       input logic ae, input logic [3:0] at, input logic [31:0] ad,
                                       input logic le, input logic [3:0] lt, input logic [31:0] ld);
        logic [35:0] e;
        bit ga, gb;
        if (!r) return;
        if (c) begin
            qa.delete();
            qb.delete();
            m_en = 0;
            return;
        end
        ga = 0; gb = 0;
        if (qa.size() > 0 && qb.size() > 0) begin
            if (m_last_lsb) ga = 1; else gb = 1;
        end else if (qa.size() > 0) ga = 1;
        else if (qb.size() > 0) gb = 1;
        if (ga) begin
            e = qa.pop_front(); m_en = 1; m_last_lsb = 0; {m_tag, m_res} = e;
        end else if (gb) begin
            e = qb.pop_front(); m_en = 1; m_last_lsb = 1; {m_tag, m_res} = e;
        end else begin
            m_en = 0;
        end
        if (ae) begin
            if (qa.size() < DEPTH) qa.push_back({at, ad}); else m_ovf = 1;
        end
        if (le) begin
            if (qb.size() < DEPTH) qb.push_back({lt, ld}); else m_ovf = 1;
        end
    endfunction

    task automatic check_model();
        checkOutput("cdb_en", 64'(cdb_en), 64'(m_en));
        checkOutput("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        checkOutput("cdb_res", 64'(cdb_res), 64'(m_res));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("alu_full", 64'(alu_full), 64'(qa.size() == DEPTH));
        checkOutput("lsb_full", 64'(lsb_full), 64'(qb.size() == DEPTH));
    endtask

    // Drive one cycle of inputs (called with clock low), clock it, check at negedge.
    task automatic applyStimulus(input logic r, input logic c,
                                 input logic ae, input logic [3:0] at, input logic [31:0] ad,
                                 input logic le, input logic [3:0] lt, input logic [31:0] ld);
        rdy = r; clear = c;
        alu_en = ae; alu_tag = at; alu_res = ad;
        lsb_en = le; lsb_tag = lt; lsb_res = ld;
        @(posedge clk);
        model_step(r, c, ae, at, ad, le, lt, ld);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; rdy = 0; clear = 0; alu_en = 0; lsb_en = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        checkOutput("rst_en", 64'(cdb_en), 64'd0);
        checkOutput("rst_tag", 64'(cdb_tag), 64'd0);
        checkOutput("rst_res", 64'(cdb_res), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
    endtask

    initial begin
        int run, max_run, total, an, ln;
        bit seen_full;
        logic r, c, ae, le;

        $display("[TB] starting cdb_arbiter bench");
        model_reset();

        // Test 1: single ALU push, two-edge latency
        do_reset();
        applyStimulus(1, 0, 1, 4'd3, 32'h11, 0, 4'd0, 32'h0);
        checkOutput("t1_lat_en", 64'(cdb_en), 64'd0);
        idle();
        checkOutput("t1_en", 64'(cdb_en), 64'd1);
        checkOutput("t1_tag", 64'(cdb_tag), 64'd3);
        checkOutput("t1_res", 64'(cdb_res), 64'h11);
        idle();
        checkOutput("t1_off", 64'(cdb_en), 64'd0);

        // Test 2: tie resolution in both round-robin states
        applyStimulus(1, 0, 1, 4'd5, 32'h55, 1, 4'd6, 32'h66);
        idle();
        checkOutput("t2_first", 64'(cdb_tag), 64'd6);
        idle();
        checkOutput("t2_second", 64'(cdb_tag), 64'd5);
        applyStimulus(1, 0, 0, 4'd0, 32'h0, 1, 4'd7, 32'h77);
        idle();
        checkOutput("t2_lsb", 64'(cdb_tag), 64'd7);
        applyStimulus(1, 0, 1, 4'd8, 32'h88, 1, 4'd9, 32'h99);
        idle();
        checkOutput("t2_alu_first", 64'(cdb_tag), 64'd8);
        idle();
        checkOutput("t2_lsb_second", 64'(cdb_tag), 64'd9);

        // Test 3: saturate both queues, overflow, FIFO drain order
        do_reset();
        seen_full = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 1, 4'(i), 32'hA00 + 32'(i), 1, 4'(i + 1), 32'hB00 + 32'(i));
            if (alu_full) seen_full = 1;
        end
        checkOutput("t3_alu_full_seen", 64'(seen_full), 64'd1);
        checkOutput("t3_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 10; i++) idle();

        // Test 4: continuous dual load with producers honouring full
        do_reset();
        an = 0; ln = 0; run = 0; max_run = 0; total = 0;
        for (int i = 0; i < 40; i++) begin
            ae = (an < 8) && !alu_full;
            le = (ln < 8) && !lsb_full;
            applyStimulus(1, 0, ae, 4'(an), 32'hC000 + 32'(an), le, 4'(8 + ln), 32'hD000 + 32'(ln));
            if (ae) an++;
            if (le) ln++;
            if (cdb_en) begin
                run++; total++;
                if (run > max_run) max_run = run;
            end else run = 0;
        end
        checkOutput("t4_run", 64'(max_run), 64'd16);
        checkOutput("t4_total", 64'(total), 64'd16);
        checkOutput("t4_ovf", 64'(overflow), 64'd0);

        // Test 5: flush with entries queued, pushes in the flush cycle discarded
        do_reset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 1, 4'(i), 32'h500 + 32'(i), 1, 4'(i + 4), 32'h600 + 32'(i));
        applyStimulus(1, 1, 1, 4'hE, 32'hEE, 1, 4'hF, 32'hFF);
        checkOutput("t5_clr_en", 64'(cdb_en), 64'd0);
        idle();
        checkOutput("t5_empty", 64'(cdb_en), 64'd0);
        applyStimulus(1, 0, 1, 4'hC, 32'hCC, 0, 4'h0, 32'h0);
        idle();
        checkOutput("t5_post_en", 64'(cdb_en), 64'd1);
        checkOutput("t5_post_tag", 64'(cdb_tag), 64'hC);

        // Test 6: freeze mid-drain, then asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 1, 4'(i), 32'h700 + 32'(i), 1, 4'(i + 8), 32'h800 + 32'(i));
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 1, 4'hA, 32'hAA, 1, 4'hB, 32'hBB);
        for (int i = 0; i < 8; i++) idle();
        applyStimulus(1, 0, 1, 4'd2, 32'h22, 1, 4'd4, 32'h44);
        applyStimulus(1, 0, 1, 4'd3, 32'h33, 1, 4'd5, 32'h55);
        checkOutput("t6_pre_en", 64'(cdb_en), 64'd1);
        #2 rst = 1;
        #1;
        checkOutput("t6_async_en", 64'(cdb_en), 64'd0);
        checkOutput("t6_async_tag", 64'(cdb_tag), 64'd0);
        checkOutput("t6_async_res", 64'(cdb_res), 64'd0);
        checkOutput("t6_async_full", 64'(alu_full | lsb_full), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 0;

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 24) == 0);
            ae = ($urandom_range(0, 1) == 1) && (!alu_full || $urandom_range(0, 19) == 0);
            le = ($urandom_range(0, 1) == 1) && (!lsb_full || $urandom_range(0, 19) == 0);
            applyStimulus(r, c, ae, 4'($urandom), 32'($urandom), le, 4'($urandom), 32'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
